// File: rtl/mod_inverse_unit.sv
// Iterative modular inverter (binary extended Euclid, one step per clock): result = a^-1 mod p.
// Optional watchdog enabled by defining ECC_INV_TIMEOUT_EN; ports are identical either way.
module mod_inverse_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] p_i,
  input  logic             inv_start_i,
  output logic             inv_busy_o,
  output logic             inv_finish_o,
  output logic             inv_error_o,
  output logic [WIDTH-1:0] inv_result_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] u_q, u_d, v_q, v_d;
  logic [WIDTH-1:0] x1_q, x1_d, x2_q, x2_d;
  logic [WIDTH-1:0] p_q, p_d, result_q, result_d;
  logic             error_q, error_d;
  logic             illegal;
  logic             wd_expired;

  assign illegal = (a_i == '0) || (a_i >= p_i) || !p_i[0] || (p_i <= WIDTH'(1));

  // Halve x modulo odd p; x+p needs one extra bit before the shift.
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] p);
    logic [WIDTH:0] s;
    s = {1'b0, x} + (x[0] ? {1'b0, p} : '0);
    return s[WIDTH:1];
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] p);
    logic [WIDTH:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (x < y) d = d + {1'b0, p};
    return d[WIDTH-1:0];
  endfunction

`ifdef ECC_INV_TIMEOUT_EN
  localparam int CW = $clog2(2 * WIDTH + 3);
  localparam logic [CW-1:0] WD_LAST = CW'(2 * WIDTH + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of RUN cycles already completed.
  assign wd_expired = (cnt_q == WD_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && inv_start_i) cnt_d = '0;
    else if (state_q == RUN)            cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    u_d      = u_q;
    v_d      = v_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    p_d      = p_q;
    result_d = result_q;
    error_d  = error_q;
    unique case (state_q)
      IDLE: begin
        if (inv_start_i) begin
          p_d     = p_i;
          u_d     = a_i;
          v_d     = p_i;
          x1_d    = WIDTH'(1);
          x2_d    = '0;
          error_d = 1'b0;
          state_d = RUN;
          if (illegal) begin
            error_d  = 1'b1;
            result_d = '0;
            state_d  = DONE;
          end
        end
      end
      RUN: begin
        if (u_q == WIDTH'(1)) begin
          result_d = x1_q;
          state_d  = DONE;
        end else if (v_q == WIDTH'(1)) begin
          result_d = x2_q;
          state_d  = DONE;
        end else if (u_q == '0 || v_q == '0 || wd_expired) begin
          error_d  = 1'b1;
          result_d = '0;
          state_d  = DONE;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = half_mod(x1_q, p_q);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = half_mod(x2_q, p_q);
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = sub_mod(x1_q, x2_q, p_q);
        end else begin
          v_d  = v_q - u_q;
          x2_d = sub_mod(x2_q, x1_q, p_q);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      u_q      <= '0;
      v_q      <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      p_q      <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      u_q      <= u_d;
      v_q      <= v_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      p_q      <= p_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign inv_busy_o   = (state_q == RUN);
  assign inv_finish_o = (state_q == DONE);
  assign inv_error_o  = error_q;
  assign inv_result_o = result_q;

endmodule
